inv_shift_rows_stream: RTL and testbench

INV_SHIFT_ROWS_STREAM -- requirements
Module: inv_shift_rows_stream

---
 rtl/inv_shift_rows_stream.sv | 116 +++++++++++
 tb/tb_inv_shift_rows_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: buffers a 16-byte state, then drains it row-rotated.
// Optional completed-block counter on blk_cnt when INV_SHIFT_ROWS_BLK_CNT_EN is defined.
module inv_shift_rows_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  // Out-of-range widths fail elaboration on a missing module.
  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    illegal_cnt_w_parameter u_bad ();
  end

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  buf_q [16];
  logic [7:0]  buf_d [16];
  logic        in_fire;
  logic        out_fire;
  logic [1:0]  row;
  logic [1:0]  src_col;
  logic [3:0]  src_idx;

  // Output byte (r, c) comes from input column (c - r) mod 4 of the same row.
  assign row      = cnt_q[1:0];
  assign src_col  = cnt_q[3:2] - row;
  assign src_idx  = {src_col, row};
  assign out_byte = buf_q[src_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_fire = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'hf) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == 4'hf);
        if (out_ready) begin
          out_fire = 1'b1;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'hf) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    if (in_fire) buf_d[cnt_q] = in_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The buffer is deliberately left out of reset; its contents only matter once refilled.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_fire && out_last) blk_cnt_d = blk_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) blk_cnt_q <= '0;
    else        blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboard bench for inv_shift_rows_stream: a matrix-level InvShiftRows model feeds
// an expected queue that a negedge monitor drains on every output handshake.
module tb_inv_shift_rows_stream;

`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
  logic [TB_CNT_W-1:0] blk_cnt;
  logic [TB_CNT_W-1:0] model_blk;
`endif

  inv_shift_rows_stream #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last)
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] partial[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cycle = 0;
  bit         mon_en = 0;
  bit         wait_first = 0;
  int         acc_cyc = 0;
  bit         hold_pend = 0;
  logic [7:0] held_b;
  logic       held_l;
  bit         stall_en = 0;
  int         stall_left = 0;

  logic [7:0] vec  [16] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                            8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
  logic [7:0] ramp [16];
  logic [7:0] rblk [16];

  always @(posedge clk) cycle++;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: lay the 16 bytes out as a 4x4 column-major matrix, rotate row r right by r.
  function automatic void push_expected();
    logic [7:0] st [4][4];
    exp_t e;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = partial[4 * c + r];
    for (int k = 0; k < 16; k++) begin
      e.b    = st[k % 4][((k / 4) - (k % 4) + 4) % 4];
      e.last = (k == 15);
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        partial.delete();
        sb.delete();
        hold_pend  = 0;
        wait_first = 0;
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
        model_blk = '0;
`endif
      end else begin
        check_output("ready_vs_valid", int'(in_ready), int'(!out_valid));
        if (hold_pend && out_valid) begin
          check_output("stall_byte", int'(out_byte), int'(held_b));
          check_output("stall_last", int'(out_last), int'(held_l));
        end
        if (out_valid && wait_first) begin
          check_output("latency", cycle - acc_cyc, 1);
          wait_first = 0;
        end
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
        check_output("blk_cnt", int'(blk_cnt), int'(model_blk));
        if (out_valid && out_ready && out_last) model_blk = model_blk + 1'b1;
`endif
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: got %0h expected none", out_byte);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check_output("out_byte", int'(out_byte), int'(e.b));
            check_output("out_last", int'(out_last), int'(e.last));
          end
        end
        hold_pend = out_valid && !out_ready;
        held_b    = out_byte;
        held_l    = out_last;
        if (in_valid && in_ready) begin
          partial.push_back(in_byte);
          if (partial.size() == 16) begin
            push_expected();
            partial.delete();
            acc_cyc    = cycle;
            wait_first = 1;
          end
        end
      end
    end
  end

  // Consumer: optional random back-pressure bursts of 1-3 cycles.
  always @(posedge clk) begin
    #1;
    if (!stall_en) out_ready = 1'b1;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 3) == 0) begin
      out_ready  = 1'b0;
      stall_left = $urandom_range(0, 2);
    end else out_ready = 1'b1;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int tries;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    acc      = 0;
    tries    = 0;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  // gap < 0 selects a random idle gap of 0..2 cycles before each byte.
  task automatic apply_stimulus(input logic [7:0] blk [16], input int gap, input int n);
    for (int k = 0; k < n; k++)
      send_byte(blk[k], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
`ifdef INV_SHIFT_ROWS_BLK_CNT_EN
    model_blk = '0;
`endif
    for (int i = 0; i < 16; i++) ramp[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check_output("reset_in_ready", int'(in_ready), 1);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;

    $display("[TB] full throughput vector");
    apply_stimulus(vec, 0, 16);
    wait_drain();

    $display("[TB] toggling in_valid");
    apply_stimulus(vec, 1, 16);
    wait_drain();

    $display("[TB] output stalls");
    stall_en = 1;
    apply_stimulus(vec, 0, 16);
    wait_drain();
    stall_en = 0;

    $display("[TB] reset after 7 bytes");
    apply_stimulus(vec, 0, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    apply_stimulus(vec, 0, 16);
    wait_drain();

    $display("[TB] back-to-back ramp then vector");
    apply_stimulus(ramp, 0, 16);
    apply_stimulus(vec, 0, 16);
    wait_drain();

    $display("[TB] 17 random blocks with stalls");
    stall_en = 1;
    for (int b = 0; b < 17; b++) begin
      for (int i = 0; i < 16; i++) rblk[i] = 8'($urandom_range(0, 255));
      apply_stimulus(rblk, -1, 16);
    end
    wait_drain();
    stall_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
